fmul_issue_ctrl: RTL and testbench

//  Sequential front/back end for the combinational fmul core: accepts multiply requests over a

---
 rtl/fmul_pkg.sv | 27 ++
 rtl/fmul_issue_ctrl_fmul.sv | 89 ++++++++
 rtl/fmul_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_fmul_issue_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared definitions for the fmul issue controller and the fmul core:
// FSM state encoding, IEEE field geometry for single/half and flag bit indices.
package fmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SGL_EXP_LSB = 23;
    localparam int SGL_EXP_W   = 8;
    localparam int SGL_MAN_W   = 23;

    localparam int HLF_EXP_LSB = 10;
    localparam int HLF_EXP_W   = 5;
    localparam int HLF_MAN_W   = 10;

    localparam int FLAG_NAN    = 3;
    localparam int FLAG_INF    = 2;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_DENORM = 0;

    localparam logic [31:0] SGL_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] HLF_QNAN = 32'h0000_7E00;

endpackage

// File: rtl/fmul_issue_ctrl_fmul.sv
// Combinational floating-point multiplier, single or half precision.
// Denormal inputs and underflowing results are flushed to signed zero.
// round_mode: 1 = round to nearest even, 0 = truncate toward zero.
module fmul
    import fmul_pkg::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mode_fp,
    input  logic        round_mode,
    output logic [31:0] re
);

    logic        sign_a, sign_b, sign_r;
    logic [7:0]  exp_a, exp_b, exp_max;
    logic [22:0] man_a, man_b;
    logic [9:0]  bias;
    logic [47:0] prod;
    logic [46:0] frac;
    logic [9:0]  exp_r;
    logic [23:0] keep;
    logic        guard, sticky, carry;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    // Unpack both operands onto a common grid: half mantissas are left-aligned into 23 bits
    always_comb begin
        if (mode_fp) begin
            sign_a  = op_a[31];
            sign_b  = op_b[31];
            exp_a   = op_a[30:23];
            exp_b   = op_b[30:23];
            man_a   = op_a[22:0];
            man_b   = op_b[22:0];
            exp_max = 8'hFF;
            bias    = 10'd127;
        end else begin
            sign_a  = op_a[15];
            sign_b  = op_b[15];
            exp_a   = {3'b000, op_a[14:10]};
            exp_b   = {3'b000, op_b[14:10]};
            man_a   = {op_a[9:0], 13'b0};
            man_b   = {op_b[9:0], 13'b0};
            exp_max = 8'h1F;
            bias    = 10'd15;
        end
    end

    // Multiply significands, normalise, round to the target width and pack with special cases
    always_comb begin
        nan_a  = (exp_a == exp_max) && (man_a != '0);
        nan_b  = (exp_b == exp_max) && (man_b != '0);
        inf_a  = (exp_a == exp_max) && (man_a == '0);
        inf_b  = (exp_b == exp_max) && (man_b == '0);
        zero_a = (exp_a == '0);
        zero_b = (exp_b == '0);
        sign_r = sign_a ^ sign_b;

        prod  = {1'b1, man_a} * {1'b1, man_b};
        frac  = prod[47] ? prod[46:0] : {prod[45:0], 1'b0};
        exp_r = {2'b00, exp_a} + {2'b00, exp_b} - bias + {9'b0, prod[47]};

        if (mode_fp) begin
            keep   = {1'b0, frac[46:24]};
            guard  = frac[23];
            sticky = |frac[22:0];
        end else begin
            keep   = {14'b0, frac[46:37]};
            guard  = frac[36];
            sticky = |frac[35:0];
        end
        keep  = keep + {23'b0, round_mode & guard & (sticky | keep[0])};
        carry = mode_fp ? keep[23] : keep[10];
        if (carry) begin
            exp_r = exp_r + 10'd1;
        end

        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            re = mode_fp ? SGL_QNAN : HLF_QNAN;
        end else if (inf_a || inf_b || ($signed(exp_r) >= $signed({2'b00, exp_max}))) begin
            re = mode_fp ? {sign_r, 8'hFF, 23'b0} : {16'b0, sign_r, 5'h1F, 10'b0};
        end else if (zero_a || zero_b || ($signed(exp_r) <= $signed(10'd0))) begin
            re = mode_fp ? {sign_r, 31'b0} : {16'b0, sign_r, 15'b0};
        end else begin
            re = mode_fp ? {sign_r, exp_r[7:0], keep[22:0]}
                         : {16'b0, sign_r, exp_r[4:0], keep[9:0]};
        end
    end

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Issue controller around the combinational fmul core: accepts a request, holds
// operands stable for MUL_CYCLES, captures and classifies the product, and
// returns it with its tag over a valid/ready handshake.
module fmul_issue_ctrl
    import fmul_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_mode_fp,
    input  logic             in_round,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
        $error("fmul_issue_ctrl: MUL_CYCLES must be in 1..15");
    end

    state_t           state;
    logic [3:0]       cnt;
    logic [31:0]      a_q, b_q;
    logic             mode_q, round_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      fmul_re;
    logic [31:0]      result_c;

    // Exactly one or none of {nan, inf, zero, denorm} for the given precision
    function automatic logic [3:0] classify(input logic [31:0] r, input logic mode_fp);
        logic       exp_ones, exp_zero, man_zero;
        logic [3:0] f;
        if (mode_fp) begin
            exp_ones = &r[SGL_EXP_LSB +: SGL_EXP_W];
            exp_zero = ~|r[SGL_EXP_LSB +: SGL_EXP_W];
            man_zero = ~|r[SGL_MAN_W-1:0];
        end else begin
            exp_ones = &r[HLF_EXP_LSB +: HLF_EXP_W];
            exp_zero = ~|r[HLF_EXP_LSB +: HLF_EXP_W];
            man_zero = ~|r[HLF_MAN_W-1:0];
        end
        f              = '0;
        f[FLAG_NAN]    = exp_ones & ~man_zero;
        f[FLAG_INF]    = exp_ones & man_zero;
        f[FLAG_ZERO]   = exp_zero & man_zero;
        f[FLAG_DENORM] = exp_zero & ~man_zero;
        return f;
    endfunction

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign result_c = mode_q ? fmul_re : {16'b0, fmul_re[15:0]};

    fmul u_fmul (
        .op_a       (a_q),
        .op_b       (b_q),
        .mode_fp    (mode_q),
        .round_mode (round_q),
        .re         (fmul_re)
    );

    // Request/compute/return sequencing; a DONE handshake can hand straight off to a new request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
            round_q    <= 1'b0;
            tag_q      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        mode_q  <= in_mode_fp;
                        round_q <= in_round;
                        tag_q   <= in_tag;
                        cnt     <= CNT_INIT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        out_result <= result_c;
                        out_tag    <= tag_q;
                        out_flags  <= classify(result_c, mode_q);
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_q     <= in_a;
                            b_q     <= in_b;
                            mode_q  <= in_mode_fp;
                            round_q <= in_round;
                            tag_q   <= in_tag;
                            cnt     <= CNT_INIT;
                            state   <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Directed testbench for fmul_issue_ctrl: arithmetic vectors, flags, latency,
// backpressure with same-cycle handoff, and reset during an in-flight request.
module tb_fmul_issue_ctrl;

    localparam int MUL_CYCLES = 2;
    localparam int TAG_W      = 4;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             in_valid   = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a       = '0;
    logic [31:0]      in_b       = '0;
    logic             in_mode_fp = 1'b0;
    logic             in_round   = 1'b0;
    logic [TAG_W-1:0] in_tag     = '0;
    logic             out_valid;
    logic             out_ready  = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    int check_count = 0;
    int error_count = 0;
    int lat;

    fmul_issue_ctrl #(
        .MUL_CYCLES (MUL_CYCLES),
        .TAG_W      (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode_fp (in_mode_fp),
        .in_round   (in_round),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, observed, expected);
        end
    endtask

    // Present a request and hold it until the handshake edge; leaves time at #1 after that edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic mode,
                                 input logic rnd, input logic [TAG_W-1:0] tag);
        logic accepted;
        in_a       = a;
        in_b       = b;
        in_mode_fp = mode;
        in_round   = rnd;
        in_tag     = tag;
        in_valid   = 1'b1;
        accepted   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (accepted) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("accept", {31'b0, accepted}, 32'd1);
    endtask

    // Counts edges from the handshake edge (inclusive) until out_valid rises, bounded
    task automatic waitResult(output int edges);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic mode, input logic rnd, input logic [TAG_W-1:0] tag,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags);
        int l;
        out_ready = 1'b1;
        applyStimulus(a, b, mode, rnd, tag);
        waitResult(l);
        checkOutput({name, "_latency"}, 32'(l), 32'(MUL_CYCLES + 1));
        checkOutput({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({name, "_result"}, out_result, exp_res);
        checkOutput({name, "_tag"}, {28'b0, out_tag}, {28'b0, tag});
        checkOutput({name, "_flags"}, {28'b0, out_flags}, {28'b0, exp_flags});
        @(posedge clk); #1;
        checkOutput({name, "_retired"}, {31'b0, out_valid}, 32'd0);
    endtask

    // Main directed sequence
    initial begin
        #1;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_result", out_result, 32'h0);
        checkOutput("rst_out_tag", {28'b0, out_tag}, 32'h0);
        checkOutput("rst_out_flags", {28'b0, out_flags}, 32'h0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        runOp("s_1x2",    32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1, 4'd1, 32'h4000_0000, 4'b0000);
        runOp("s_3x4",    32'h4040_0000, 32'h4080_0000, 1'b1, 1'b1, 4'd5, 32'h4140_0000, 4'b0000);
        runOp("h_1x2",    32'hABCD_3C00, 32'h0000_4000, 1'b0, 1'b1, 4'd2, 32'h0000_4000, 4'b0000);
        runOp("s_inf",    32'h7F80_0000, 32'h3F80_0000, 1'b1, 1'b1, 4'd3, 32'h7F80_0000, 4'b0100);
        runOp("s_zero",   32'h0000_0000, 32'h4000_0000, 1'b1, 1'b1, 4'd4, 32'h0000_0000, 4'b0010);
        runOp("h_nan",    32'h0000_7E01, 32'h0000_3C00, 1'b0, 1'b1, 4'd6, 32'h0000_7E00, 4'b1000);
        runOp("s_rne",    32'h3F80_0001, 32'h3FC0_0000, 1'b1, 1'b1, 4'd8, 32'h3FC0_0002, 4'b0000);
        runOp("s_trunc",  32'h3F80_0001, 32'h3FC0_0000, 1'b1, 1'b0, 4'd9, 32'h3FC0_0001, 4'b0000);
        runOp("s_neg",    32'hC040_0000, 32'h4080_0000, 1'b1, 1'b1, 4'd10, 32'hC140_0000, 4'b0000);

        // Backpressure: result held while a second request waits, then same-cycle handoff
        out_ready = 1'b0;
        applyStimulus(32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1, 4'd7);
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'(MUL_CYCLES + 1));
        in_a       = 32'h4040_0000;
        in_b       = 32'h4080_0000;
        in_mode_fp = 1'b1;
        in_tag     = 4'd9;
        in_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_hold_result", out_result, 32'h4000_0000);
            checkOutput("bp_hold_tag", {28'b0, out_tag}, 32'd7);
            checkOutput("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp_handoff_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("bp_busy_in_ready", {31'b0, in_ready}, 32'd0);
        waitResult(lat);
        checkOutput("bp2_latency", 32'(lat), 32'(MUL_CYCLES + 1));
        checkOutput("bp2_result", out_result, 32'h4140_0000);
        checkOutput("bp2_tag", {28'b0, out_tag}, 32'd9);
        @(posedge clk); #1;

        // Reset while BUSY abandons the request and clears the held result
        out_ready = 1'b1;
        applyStimulus(32'h4040_0000, 32'h4080_0000, 1'b1, 1'b1, 4'd3);
        checkOutput("rb_busy", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rb_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rb_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rb_out_result", out_result, 32'h0);
        checkOutput("rb_out_tag", {28'b0, out_tag}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("rb_no_stale", {31'b0, out_valid}, 32'd0);
        end
        runOp("post_rst", 32'h4000_0000, 32'h4000_0000, 1'b1, 1'b1, 4'd12, 32'h4080_0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
